// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared framebuffer geometry, bank bases, fill FSM states and pointer helper
package vga_fb_pkg;
  localparam int FB_WORDS = 19200;
  localparam int FB_BANK_WORDS = 16384;
  localparam int AW = 15;
  localparam logic [AW-1:0] VGA_BANK0_BASE = 15'h0000;
  localparam logic [AW-1:0] VGA_BANK1_BASE = 15'h4000;
  typedef enum logic [1:0] {IDLE, WAIT_VS, FILL} fill_state_t;
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(FB_WORDS - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/vga_fb_fill_ctrl_if.sv
// vga_fb_fill_ctrl_if: MCU store bus in, framebuffer write port out
//   cpu_wr/cpu_addr/cpu_ble/cpu_wdata : MCU store (master drives)
//   fb_we/fb_addr/fb_ble/fb_wdata     : framebuffer write port (slave drives)
interface vga_fb_fill_ctrl_if;
  import vga_fb_pkg::*;
  logic cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [3:0] cpu_ble;
  logic [31:0] cpu_wdata;
  logic fb_we;
  logic [AW-1:0] fb_addr;
  logic [3:0] fb_ble;
  logic [31:0] fb_wdata;
  modport master(output cpu_wr, cpu_addr, cpu_ble, cpu_wdata, input fb_we, fb_addr, fb_ble, fb_wdata);
  modport slave(input cpu_wr, cpu_addr, cpu_ble, cpu_wdata, output fb_we, fb_addr, fb_ble, fb_wdata);
endinterface

// File: rtl/vga_fb_wr_mux.sv
// vga_fb_wr_mux: registered 2:1 framebuffer write mux, CPU store always wins
//   cpu_*  : MCU store request      fill_* : fill engine request
//   fill_grant : fill word accepted this cycle
//   fb_*   : registered write port; address/lanes/data hold when idle
module vga_fb_wr_mux import vga_fb_pkg::*; (
  input  logic          clk,
  input  logic          resetb,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [3:0]    cpu_ble,
  input  logic [31:0]   cpu_wdata,
  input  logic          fill_req,
  input  logic [AW-1:0] fill_addr,
  input  logic [31:0]   fill_wdata,
  output logic          fill_grant,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [3:0]    fb_ble,
  output logic [31:0]   fb_wdata
);
  logic fb_we_q;
  logic [AW-1:0] fb_addr_q;
  logic [3:0] fb_ble_q;
  logic [31:0] fb_wdata_q;
  assign fill_grant = fill_req & ~cpu_wr;
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      fb_we_q <= 1'b0;
      fb_addr_q <= '0;
      fb_ble_q <= '0;
      fb_wdata_q <= '0;
    end else begin
      fb_we_q <= cpu_wr | fill_req;
      if (cpu_wr) begin
        fb_addr_q <= cpu_addr;
        fb_ble_q <= cpu_ble;
        fb_wdata_q <= cpu_wdata;
      end else if (fill_req) begin
        fb_addr_q <= fill_addr;
        fb_ble_q <= 4'hF;
        fb_wdata_q <= fill_wdata;
      end
    end
  end
  assign fb_we = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_ble = fb_ble_q;
  assign fb_wdata = fb_wdata_q;
endmodule

// File: rtl/vga_fb_fill_ctrl.sv
// vga_fb_fill_ctrl: merges MCU stores with a colour-fill engine onto the framebuffer write port
//   bus       : MCU store in / framebuffer write port out
//   vga_vs    : active-low vsync, synchronous to clk
//   cfg_*     : start/abort pulses, vsync-sync select, base, length, colour
//   busy/done : engine active (WAIT_VS or FILL) / one-cycle completion pulse
module vga_fb_fill_ctrl import vga_fb_pkg::*; (
  input  logic                 clk,
  input  logic                 resetb,
  vga_fb_fill_ctrl_if.slave    bus,
  input  logic                 vga_vs,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic                 cfg_sync,
  input  logic [AW-1:0]        cfg_base,
  input  logic [AW-1:0]        cfg_len,
  input  logic [7:0]           cfg_color,
  output logic                 busy,
  output logic                 done
);
  fill_state_t state_q;
  logic [AW-1:0] ptr_q, cnt_q;
  logic [31:0] color_q;
  logic vs_q, busy_q, done_q, fill_req, fill_grant;
  // cnt_q==0 in FILL is the closing cycle: all words issued, done raised next
  assign fill_req = (state_q == FILL) && (cnt_q != '0);
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      color_q <= '0;
      vs_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vs_q <= vga_vs;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (cfg_start) begin
          if (cfg_len == '0) done_q <= 1'b1;
          else begin
            ptr_q <= cfg_base;
            cnt_q <= cfg_len;
            color_q <= {4{cfg_color}};
            state_q <= cfg_sync ? WAIT_VS : FILL;
            busy_q <= 1'b1;
          end
        end
        WAIT_VS: if (cfg_abort) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end else if (!vga_vs && vs_q) state_q <= FILL;
        FILL: begin
          if (fill_grant) begin
            ptr_q <= next_ptr(ptr_q);
            cnt_q <= cnt_q - 1'b1;
          end
          // a word issued in the abort cycle is still written by the mux
          if (cfg_abort || cnt_q == '0) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            done_q <= !cfg_abort && cnt_q == '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  vga_fb_wr_mux u_mux (
    .clk(clk), .resetb(resetb),
    .cpu_wr(bus.cpu_wr), .cpu_addr(bus.cpu_addr), .cpu_ble(bus.cpu_ble), .cpu_wdata(bus.cpu_wdata),
    .fill_req(fill_req), .fill_addr(ptr_q), .fill_wdata(color_q), .fill_grant(fill_grant),
    .fb_we(bus.fb_we), .fb_addr(bus.fb_addr), .fb_ble(bus.fb_ble), .fb_wdata(bus.fb_wdata)
  );
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_vga_fb_fill_ctrl.sv
// tb_vga_fb_fill_ctrl: directed stimulus, queue-based write model and per-cycle compare
module tb_vga_fb_fill_ctrl;
  import vga_fb_pkg::*;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic vga_vs = 1'b1;
  logic cfg_start = 1'b0, cfg_abort = 1'b0, cfg_sync = 1'b0;
  logic [AW-1:0] cfg_base = '0, cfg_len = '0;
  logic [7:0] cfg_color = '0;
  logic busy, done;
  vga_fb_fill_ctrl_if bus();
  vga_fb_fill_ctrl dut (
    .clk(clk), .resetb(resetb), .bus(bus), .vga_vs(vga_vs),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_sync(cfg_sync),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_color(cfg_color),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a started fill is a queue of word addresses; each cycle the CPU store
  // takes the port if present, otherwise the next queued word goes out
  logic e_we = 0, e_busy = 0, e_done = 0;
  logic [AW-1:0] e_addr = '0;
  logic [3:0] e_ble = '0;
  logic [31:0] e_wd = '0;
  int wq[$];
  int mode = 0;
  logic [31:0] m_color = '0;
  logic m_vs = 1'b0;
  initial forever begin
    @(posedge clk or negedge resetb);
    if (!resetb) begin
      {e_we, e_busy, e_done, e_addr, e_ble, e_wd} = '0;
      wq.delete();
      mode = 0;
      m_vs = 1'b0;
    end else begin
      e_we = 1'b0;
      e_done = 1'b0;
      if (bus.cpu_wr) begin
        e_we = 1'b1; e_addr = bus.cpu_addr; e_ble = bus.cpu_ble; e_wd = bus.cpu_wdata;
      end
      if (mode == 0) begin
        if (cfg_start) begin
          if (cfg_len == '0) e_done = 1'b1;
          else begin
            for (int i = 0; i < int'(cfg_len); i++) wq.push_back((int'(cfg_base) + i) % FB_WORDS);
            m_color = {4{cfg_color}};
            mode = cfg_sync ? 1 : 2;
          end
        end
      end else if (mode == 1) begin
        if (cfg_abort) mode = 0;
        else if (!vga_vs && m_vs) mode = 2;
      end else begin
        if (wq.size() == 0) begin
          mode = 0;
          e_done = !cfg_abort;
        end else begin
          if (!bus.cpu_wr) begin
            e_we = 1'b1; e_addr = AW'(wq.pop_front()); e_ble = 4'hF; e_wd = m_color;
          end
          if (cfg_abort) begin mode = 0; wq.delete(); end
        end
      end
      m_vs = vga_vs;
      e_busy = (mode != 0);
    end
  end

  int cyc = 0, done_cnt = 0, busy_cnt = 0, first_cyc = 0, done_cyc = 0;
  logic [31:0] l_addr[$], l_data[$], l_ble[$];
  always @(negedge clk) begin
    cyc++;
    check("fb_we", {31'b0, bus.fb_we}, {31'b0, e_we});
    check("fb_addr", {17'b0, bus.fb_addr}, {17'b0, e_addr});
    check("fb_ble", {28'b0, bus.fb_ble}, {28'b0, e_ble});
    check("fb_wdata", bus.fb_wdata, e_wd);
    check("busy", {31'b0, busy}, {31'b0, e_busy});
    check("done", {31'b0, done}, {31'b0, e_done});
    if (bus.fb_we) begin
      if (l_addr.size() == 0) first_cyc = cyc;
      l_addr.push_back({17'b0, bus.fb_addr});
      l_data.push_back(bus.fb_wdata);
      l_ble.push_back({28'b0, bus.fb_ble});
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic clear_log();
    l_addr.delete(); l_data.delete(); l_ble.delete();
    done_cnt = 0; busy_cnt = 0; first_cyc = 0; done_cyc = 0;
  endtask
  task automatic start(input int base, input int len, input logic [7:0] color, input logic sync);
    cfg_base = AW'(base); cfg_len = AW'(len); cfg_color = color; cfg_sync = sync;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask
  task automatic cpu_store(input logic [AW-1:0] a, input logic [3:0] b, input logic [31:0] d);
    bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_ble = b; bus.cpu_wdata = d;
  endtask

  initial begin
    int fall_cyc;
    bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_ble = '0; bus.cpu_wdata = '0;
    cpu_store(15'h7FFF, 4'hF, 32'hFFFF_FFFF);
    tick(3);
    check("rst_we", {31'b0, bus.fb_we}, 32'd0);
    check("rst_wdata", bus.fb_wdata, 32'd0);
    cpu_store(15'h0123, 4'b0101, 32'hA5A5_A5A5);
    clear_log();
    resetb = 1'b1;
    tick(1);
    bus.cpu_wr = 1'b0;
    tick(3);
    check("cpu_cnt", l_addr.size(), 1);
    check("cpu_addr", l_addr[0], 32'h123);
    check("cpu_ble", l_ble[0], 32'h5);
    check("cpu_data", l_data[0], 32'hA5A5_A5A5);

    clear_log();
    start(100, 8, 8'h3C, 1'b0);
    tick(12);
    check("plain_cnt", l_addr.size(), 8);
    check("plain_first", l_addr[0], 100);
    check("plain_last", l_addr[7], 107);
    check("plain_data", l_data[3], 32'h3C3C_3C3C);
    check("plain_ble", l_ble[5], 32'hF);
    check("plain_busy", busy_cnt, 9);
    check("plain_done", done_cnt, 1);
    check("plain_lat", done_cyc - first_cyc, 8);

    clear_log();
    start(100, 8, 8'h3C, 1'b0);
    tick(2);
    cpu_store(15'h4005, 4'b0011, 32'hDEAD_BEEF);
    tick(1);
    cpu_store(15'h4006, 4'b1100, 32'hCAFE_F00D);
    tick(1);
    bus.cpu_wr = 1'b0;
    tick(12);
    check("cont_cnt", l_addr.size(), 10);
    check("cont_cpu0", l_addr[2], 32'h4005);
    check("cont_cpu1", l_data[3], 32'hCAFE_F00D);
    check("cont_fill3", l_addr[4], 102);
    check("cont_last", l_addr[9], 107);
    check("cont_lat", done_cyc - first_cyc, 10);
    check("cont_done", done_cnt, 1);

    clear_log();
    start(19198, 4, 8'h81, 1'b0);
    tick(8);
    check("wrap_a1", l_addr[1], 19199);
    check("wrap_a2", l_addr[2], 0);
    check("wrap_a3", l_addr[3], 1);

    clear_log();
    start(200, 3, 8'h11, 1'b1);
    tick(50);
    check("vs_nowr", l_addr.size(), 0);
    check("vs_busy", {31'b0, busy}, 32'd1);
    vga_vs = 1'b0;
    fall_cyc = cyc + 1;
    tick(8);
    vga_vs = 1'b1;
    check("vs_lat", first_cyc - fall_cyc, 2);
    check("vs_cnt", l_addr.size(), 3);
    check("vs_done", done_cnt, 1);

    clear_log();
    start(300, 10, 8'h77, 1'b0);
    tick(2);
    cfg_abort = 1'b1;
    tick(1);
    cfg_abort = 1'b0;
    tick(15);
    check("abort_cnt", l_addr.size(), 3);
    check("abort_done", done_cnt, 0);
    check("abort_busy", {31'b0, busy}, 32'd0);

    clear_log();
    start(0, 0, 8'hEE, 1'b0);
    tick(4);
    check("len0_cnt", l_addr.size(), 0);
    check("len0_done", done_cnt, 1);
    check("len0_busy", busy_cnt, 0);

    clear_log();
    start(500, 6, 8'h22, 1'b0);
    tick(2);
    start(600, 4, 8'h99, 1'b0);
    tick(12);
    check("busy_cnt", l_addr.size(), 6);
    check("busy_last", l_addr[5], 505);
    check("busy_data", l_data[5], 32'h2222_2222);
    check("busy_done", done_cnt, 1);

    start(700, 10, 8'h55, 1'b0);
    tick(4);
    resetb = 1'b0;
    #1;
    check("mid_rst_we", {31'b0, bus.fb_we}, 32'd0);
    check("mid_rst_addr", {17'b0, bus.fb_addr}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    tick(2);
    resetb = 1'b1;
    clear_log();
    tick(15);
    check("mid_rst_nores", l_addr.size(), 0);
    check("mid_rst_idle", busy_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
